adder_tree_pipe: RTL

ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

---
 rtl/adder_tree_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: sums N_IN two's-complement channels over ceil(log2(N_IN))
// register stages, then registers the result with optional saturation and an overflow flag.
module adder_tree_pipe #(
    parameter int unsigned N_IN         = 5,
    parameter int unsigned input_width  = 37,
    parameter int unsigned output_width = 40,
    parameter int unsigned SAT          = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        din_valid,
    input  logic [N_IN*input_width-1:0] din,
    output logic [output_width-1:0]     dout,
    output logic                        dout_valid,
    output logic                        ovf
);
    localparam int unsigned L  = $clog2(N_IN);
    localparam int unsigned W  = input_width + L;
    localparam int unsigned OW = output_width;

    // Number of operands present at tree level k.
    function automatic int unsigned node_cnt(input int unsigned k);
        return (N_IN + (32'd1 << k) - 32'd1) >> k;
    endfunction

    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int unsigned Cnt = node_cnt(k);
        logic v;

        if (k == 0) begin : g_v0
            assign v = din_valid;
        end else begin : g_vk
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v <= 1'b0;
                end else if (en) begin
                    v <= g_lvl[k-1].v;
                end
            end
        end

        for (genvar j = 0; j < Cnt; j++) begin : g_node
            logic signed [W-1:0] q;

            if (k == 0) begin : g_in
                assign q = W'($signed(din[j*input_width +: input_width]));
            end else begin : g_reg
                localparam int unsigned Prev = node_cnt(k - 1);
                logic signed [W-1:0] d;

                if (2 * j + 1 < Prev) begin : g_pair
                    assign d = g_lvl[k-1].g_node[2*j].q + g_lvl[k-1].g_node[2*j+1].q;
                end else begin : g_pass
                    assign d = g_lvl[k-1].g_node[2*j].q;
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        q <= '0;
                    end else if (en) begin
                        q <= d;
                    end
                end
            end
        end
    end

    logic signed [W-1:0] sum;
    logic [OW-1:0]       dout_d;
    logic                ovf_d;

    assign sum = g_lvl[L].g_node[0].q;

    if (OW >= W) begin : g_wide
        assign dout_d = OW'(sum);
        assign ovf_d  = 1'b0;
    end else begin : g_narrow
        // The sum fits only if every bit from the output sign bit upward matches.
        logic [W-OW:0] top;
        assign top   = sum[W-1:OW-1];
        assign ovf_d = !((&top) || !(|top));

        if (SAT != 0) begin : g_sat
            assign dout_d = ovf_d ? {sum[W-1], {(OW - 1){!sum[W-1]}}} : sum[OW-1:0];
        end else begin : g_wrap
            assign dout_d = sum[OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else if (en) begin
            dout       <= dout_d;
            dout_valid <= g_lvl[L].v;
            ovf        <= g_lvl[L].v & ovf_d;
        end
    end

endmodule
